// File: rtl/tile_pkg.sv
// Shared constants and types for the background tile capture/restore path.
package tile_pkg;
  localparam int TILE_DIM    = 20;
  localparam int TILE_PIXELS = 400;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int GRID_COLS   = 8;
  localparam int GRID_ROWS   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] gx;
    logic [2:0] gy;
  } cell_req_t;

  function automatic logic cell_in_range(logic [3:0] gx, logic [3:0] gy);
    return (gx < 4'(GRID_COLS)) && (gy < 4'(GRID_ROWS));
  endfunction
endpackage

// File: rtl/fb_address_translator_160x120.sv
// Row-major framebuffer address: y*160 + x, built from shifts (160 = 128 + 32).
module fb_address_translator_160x120 (
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  output logic [14:0] addr
);
  assign addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
endmodule

// File: rtl/tile_capture.sv
// Copies one 20x20 grid cell from the background framebuffer into the tile buffer.
module tile_capture
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  grid_x,
  input  logic [3:0]  grid_y,
  output logic [14:0] fb_addr,
  input  logic [8:0]  fb_q,
  output logic [8:0]  tile_addr,
  output logic [8:0]  tile_data,
  output logic        tile_wren,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t    state;
  cell_req_t req_q;
  logic [4:0] px, py;
  logic       last_px, last_py;
  logic [2:0] cell_gx, cell_gy;
  logic [4:0] nx, ny;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [14:0] nxt_addr;

  assign last_px   = (px == 5'(TILE_DIM - 1));
  assign last_py   = (py == 5'(TILE_DIM - 1));
  assign tile_data = fb_q;

  // Address of the pixel read next cycle; in IDLE this is pixel 0 of the requested cell.
  always_comb begin
    cell_gx = req_q.gx;
    cell_gy = req_q.gy;
    nx      = last_px ? 5'd0 : px + 5'd1;
    ny      = last_px ? py + 5'd1 : py;
    if (state == ST_IDLE) begin
      cell_gx = grid_x[2:0];
      cell_gy = grid_y[2:0];
      nx      = 5'd0;
      ny      = 5'd0;
    end
  end

  assign pix_x = 8'(cell_gx) * 8'(TILE_DIM) + 8'(nx);
  assign pix_y = 7'(cell_gy) * 7'(TILE_DIM) + 7'(ny);

  fb_address_translator_160x120 u_xlat (
    .x    (pix_x),
    .y    (pix_y),
    .addr (nxt_addr)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      px        <= '0;
      py        <= '0;
      fb_addr   <= '0;
      tile_addr <= '0;
      tile_wren <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cell_in_range(grid_x, grid_y)) begin
              req_q   <= '{gx: grid_x[2:0], gy: grid_y[2:0]};
              px      <= '0;
              py      <= '0;
              fb_addr <= nxt_addr;
              busy    <= 1'b1;
              state   <= ST_READ;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_FINISH;
            end
          end
        end
        ST_READ: begin
          // Write stage trails the read by one cycle to meet fb_q.
          tile_wren <= 1'b1;
          tile_addr <= 9'(py) * 9'(TILE_DIM) + 9'(px);
          if (last_px) begin
            px <= '0;
            if (last_py) begin
              state <= ST_DRAIN;
            end else begin
              py      <= py + 5'd1;
              fb_addr <= nxt_addr;
            end
          end else begin
            px      <= px + 5'd1;
            fb_addr <= nxt_addr;
          end
        end
        ST_DRAIN: begin
          tile_wren <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_FINISH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_capture.sv
// Directed bench for tile_capture with a framebuffer model holding word[a] = a[8:0].
module tb_tile_capture;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  grid_x = '0, grid_y = '0;
  logic [14:0] fb_addr;
  logic [8:0]  fb_q = '0;
  logic [8:0]  tile_addr, tile_data;
  logic        tile_wren, busy, done, err;

  int checks = 0;
  int errors = 0;

  tile_capture dut (
    .clk(clk), .resetn(resetn), .start(start), .grid_x(grid_x), .grid_y(grid_y),
    .fb_addr(fb_addr), .fb_q(fb_q), .tile_addr(tile_addr), .tile_data(tile_data),
    .tile_wren(tile_wren), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fb_q <= fb_addr[8:0];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_word(int gx, int gy, int k);
    return (((gy * 20 + k / 20) * 160) + gx * 20 + k % 20) & 511;
  endfunction

  typedef struct {
    int gx, gy;
    int again_n, rst_at;
    int exp_err, exp_wr, exp_done_n, exp_busy, exp_fb_first, exp_fb_last;
  } vec_t;

  int wr_cnt, bad_wr, first_wr_n, last_wr_n, done_cnt, done_n, err_at_done;
  int err_stray, busy_cnt, fb_first, fb_last, fb_max;

  task automatic run(input int gx, input int gy, input int again_n, input int rst_at);
    wr_cnt = 0; bad_wr = 0; first_wr_n = -1; last_wr_n = -1; done_cnt = 0; done_n = -1;
    err_at_done = -1; err_stray = 0; busy_cnt = 0; fb_first = -1; fb_last = -1; fb_max = 0;
    @(negedge clk);
    grid_x = 4'(gx); grid_y = 4'(gy); start = 1'b1;
    for (int n = 1; n <= 410; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (tile_wren) begin
        if (int'(tile_addr) != wr_cnt || int'(tile_data) != exp_word(gx, gy, wr_cnt)) bad_wr++;
        if (wr_cnt == 0) first_wr_n = n;
        last_wr_n = n;
        wr_cnt++;
      end
      if (done) begin done_cnt++; done_n = n; err_at_done = int'(err); end
      if (err && !done) err_stray++;
      if (busy) busy_cnt++;
      if (n == 1) fb_first = int'(fb_addr);
      if (n == 400) fb_last = int'(fb_addr);
      if (int'(fb_addr) > fb_max) fb_max = int'(fb_addr);
      if (n == again_n) begin grid_x = 4'd0; grid_y = 4'd0; start = 1'b1; end
      if (n == again_n + 1) start = 1'b0;
      if (n == rst_at) resetn = 1'b0;
      if (n == rst_at + 1) resetn = 1'b1;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int cd, fw, dn;
    logic found;
    vecs[0] = '{0, 0, -1, -1, 0, 400, 402, 401, 0, 3059};
    vecs[1] = '{7, 5, -1, -1, 0, 400, 402, 401, 16140, 19199};
    vecs[2] = '{8, 0, -1, -1, 1, 0, 1, 0, -1, -1};
    vecs[3] = '{0, 6, -1, -1, 1, 0, 1, 0, -1, -1};
    vecs[4] = '{2, 1, 100, -1, 0, 400, 402, 401, 3240, 6299};
    vecs[5] = '{5, 3, -1, 200, 0, 199, -1, 200, 9700, -1};
    vecs[6] = '{3, 2, -1, -1, 0, 400, 402, 401, 6460, 9519};
    vecs[7] = '{7, 0, -1, -1, 0, 400, 402, 401, 140, 3199};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wren", int'(tile_wren), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_tile_addr", int'(tile_addr), 0);
    chk("rst_tile_data", int'(tile_data), int'(fb_q));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run(vecs[i].gx, vecs[i].gy, vecs[i].again_n, vecs[i].rst_at);
      chk($sformatf("v%0d_writes", i), wr_cnt, vecs[i].exp_wr);
      chk($sformatf("v%0d_bad_writes", i), bad_wr, 0);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, vecs[i].exp_done_n >= 0 ? 1 : 0);
      chk($sformatf("v%0d_done_cycle", i), done_n, vecs[i].exp_done_n);
      chk($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
      chk($sformatf("v%0d_err_stray", i), err_stray, 0);
      chk($sformatf("v%0d_fb_in_range", i), int'(fb_max <= 19199), 1);
      if (vecs[i].exp_done_n >= 0)
        chk($sformatf("v%0d_err", i), err_at_done, vecs[i].exp_err);
      if (vecs[i].exp_wr > 0) begin
        chk($sformatf("v%0d_first_wr", i), first_wr_n, 2);
        chk($sformatf("v%0d_last_wr", i), last_wr_n, vecs[i].exp_wr + 1);
      end
      if (vecs[i].exp_fb_first >= 0)
        chk($sformatf("v%0d_fb_first", i), fb_first, vecs[i].exp_fb_first);
      if (vecs[i].exp_fb_last >= 0)
        chk($sformatf("v%0d_fb_last", i), fb_last, vecs[i].exp_fb_last);
    end

    // Back-to-back: start the next capture the cycle after done.
    @(negedge clk);
    grid_x = 4'd4; grid_y = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (done) found = 1'b1;
      else @(negedge clk);
    end
    chk("b2b_first_done_seen", int'(found), 1);
    @(posedge clk); #1;
    grid_x = 4'd1; grid_y = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fw = -1; dn = -1; cd = 0;
    for (int m = 2; m <= 420; m++) begin
      @(negedge clk);
      if (tile_wren && fw < 0) begin
        fw = m;
        cd = int'(tile_data);
      end
      if (done && dn < 0) dn = m;
    end
    chk("b2b_first_write", fw, 3);
    chk("b2b_first_data", cd, exp_word(1, 0, 0));
    chk("b2b_done", dn, 403);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
